// File: rtl/tetris_pkg.sv
// Shared constants, painter state encoding and cell-address helper for the
// board drawing path (frame is SCREEN_W x SCREEN_H colour indices).
package tetris_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int CELL_PX  = 20;
    localparam int ADDR_W   = 19;
    localparam int INDEX_W  = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        PAINT = 1'b1
    } painterState_e;

    // Frame address of a cell's top-left pixel, wrapping at ADDR_W bits.
    function automatic logic [ADDR_W-1:0] cellBase(
        input logic [4:0]        row,
        input logic [3:0]        col,
        input logic [ADDR_W-1:0] x0,
        input logic [ADDR_W-1:0] y0
    );
        logic [ADDR_W-1:0] topY;
        topY = y0 + ADDR_W'(row) * ADDR_W'(CELL_PX);
        return topY * ADDR_W'(SCREEN_W) + x0 + ADDR_W'(col) * ADDR_W'(CELL_PX);
    endfunction

endpackage

// File: rtl/tile_painter_if.sv
// Request handshake from game logic plus the frame-memory write port.
// master = requester / memory side, slave = tile_painter.
interface tile_painter_if;

    logic                           req_valid;
    logic                           req_ready;
    logic [3:0]                     req_col;
    logic [4:0]                     req_row;
    logic [tetris_pkg::INDEX_W-1:0] req_index;
    logic                           wren;
    logic [tetris_pkg::ADDR_W-1:0]  wr_addr;
    logic [tetris_pkg::INDEX_W-1:0] wr_data;
    logic                           done;
    logic                           err;

    modport master (
        output req_valid, req_col, req_row, req_index,
        input  req_ready, wren, wr_addr, wr_data, done, err
    );

    modport slave (
        input  req_valid, req_col, req_row, req_index,
        output req_ready, wren, wr_addr, wr_data, done, err
    );

endinterface

// File: rtl/tile_scan_counter.sv
// Raster scan over one cell: px/py counters and running row-base address.
// Exposes the address and border flag of the pixel that follows the current one.
module tile_scan_counter
    import tetris_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] nextAddr,
    output logic              nextOnEdge,
    output logic              lastPixel
);

    localparam logic [4:0] LAST = 5'(CELL_PX - 1);

    logic [4:0]        px;
    logic [4:0]        py;
    logic [4:0]        nextPx;
    logic [4:0]        nextPy;
    logic [ADDR_W-1:0] rowBase;
    logic [ADDR_W-1:0] nextRowBase;
    logic              wrapX;

    always_comb begin
        wrapX       = (px == LAST);
        nextPx      = wrapX ? 5'd0 : px + 5'd1;
        nextPy      = wrapX ? py + 5'd1 : py;
        nextRowBase = wrapX ? rowBase + ADDR_W'(SCREEN_W) : rowBase;
        nextAddr    = nextRowBase + ADDR_W'(nextPx);
        nextOnEdge  = (nextPx == 5'd0) || (nextPx == LAST) ||
                      (nextPy == 5'd0) || (nextPy == LAST);
        lastPixel   = wrapX && (py == LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            px      <= '0;
            py      <= '0;
            rowBase <= '0;
        end else if (start) begin
            px      <= '0;
            py      <= '0;
            rowBase <= base;
        end else if (step) begin
            px      <= nextPx;
            py      <= nextPy;
            rowBase <= nextRowBase;
        end
    end

endmodule

// File: rtl/tile_painter.sv
// Paints one 20x20 board cell into the colour-index frame, one pixel per clock.
// Optional outline colour when TILE_PAINTER_BORDER_EN is defined.
//
// state | meaning
// IDLE  | ready for a request; out-of-range requests pulse err and are dropped
// PAINT | streaming 400 raster-order writes; requests ignored
module tile_painter
    import tetris_pkg::*;
#(
    parameter int unsigned         BOARD_X0     = 200,
    parameter int unsigned         BOARD_Y0     = 0,
    parameter int unsigned         COLS         = 10,
    parameter int unsigned         ROWS         = 24,
    parameter logic [INDEX_W-1:0]  BORDER_INDEX = 8'd1
) (
    input logic          clock,
    input logic          reset,
    tile_painter_if.slave bus
);

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_PAINT = PAINT;

    logic [0:0]         state;
    logic [INDEX_W-1:0] latchedIndex;
    logic [ADDR_W-1:0]  base;
    logic [ADDR_W-1:0]  nextAddr;
    logic               nextOnEdge;
    logic               lastPixel;
    logic               accept;
    logic               inRange;
    logic               startScan;
    logic               stepScan;
    logic [INDEX_W-1:0] firstData;
    logic [INDEX_W-1:0] nextData;

    assign bus.req_ready = (state == ST_IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign inRange       = (32'(bus.req_col) < COLS) && (32'(bus.req_row) < ROWS);
    assign startScan     = accept && inRange;
    assign stepScan      = (state == ST_PAINT) && !lastPixel;
    assign base          = cellBase(bus.req_row, bus.req_col,
                                    ADDR_W'(BOARD_X0), ADDR_W'(BOARD_Y0));

`ifdef TILE_PAINTER_BORDER_EN
    // Scan always begins on the top-left corner, which is part of the outline.
    assign firstData = BORDER_INDEX;
    assign nextData  = nextOnEdge ? BORDER_INDEX : latchedIndex;
`else
    logic unusedBorder;
    assign firstData    = bus.req_index;
    assign nextData     = latchedIndex;
    assign unusedBorder = ^{BORDER_INDEX, nextOnEdge};
`endif

    tile_scan_counter scan (
        .clock     (clock),
        .reset     (reset),
        .start     (startScan),
        .step      (stepScan),
        .base      (base),
        .nextAddr  (nextAddr),
        .nextOnEdge(nextOnEdge),
        .lastPixel (lastPixel)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            latchedIndex <= '0;
            bus.wren     <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (inRange) begin
                            state        <= ST_PAINT;
                            latchedIndex <= bus.req_index;
                            bus.wren     <= 1'b1;
                            bus.wr_addr  <= base;
                            bus.wr_data  <= firstData;
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                end
                ST_PAINT: begin
                    if (lastPixel) begin
                        state    <= ST_IDLE;
                        bus.wren <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        bus.wr_addr <= nextAddr;
                        bus.wr_data <= nextData;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_painter.sv
// Self-checking bench for tile_painter: cycle-level model of accepted tiles
// and their expected pixel writes, checked every cycle, plus directed literals.
module tb_tile_painter;
    import tetris_pkg::*;

    localparam int         X0    = 200;
    localparam int         Y0    = 0;
    localparam int         NCOLS = 10;
    localparam int         NROWS = 24;
    localparam logic [7:0] BIDX  = 8'd1;
`ifdef TILE_PAINTER_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    tile_painter_if bus ();

    tile_painter #(
        .BOARD_X0(X0), .BOARD_Y0(Y0), .COLS(NCOLS), .ROWS(NROWS), .BORDER_INDEX(BIDX)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int a;
        int d;
    } wr_t;

    wr_t expQ[$];
    int  cyc = 0;
    int  winStart = -1000;
    int  winEnd = -1000;
    int  doneAt = -1;
    int  errAt = -1;
    int  resetAt = -1;
    int  checks = 0;
    int  failures = 0;
    int  logCount = 0;
    int  addrLog[4096];
    int  dataLog[4096];
    int  doneCount = 0;
    int  errCount = 0;
    int  accCount = 0;
    int  accCyc[16];
    int  lastA = 0;
    int  lastD = 0;

    function automatic int cellAddr(int col, int row, int x, int y);
        return (Y0 + row * CELL_PX + y) * SCREEN_W + X0 + col * CELL_PX + x;
    endfunction

    function automatic int cellData(int idx, int x, int y);
        if (BORDER && (x == 0 || x == CELL_PX - 1 || y == 0 || y == CELL_PX - 1))
            return int'(BIDX);
        return idx;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: decides acceptance from the documented 401-cycle tile timing.
    always @(posedge clock) begin
        int c;
        c = cyc;
        if (reset) begin
            expQ.delete();
            winStart = -1000;
            winEnd   = -1000;
            doneAt   = -1;
            errAt    = -1;
            resetAt  = c + 1;
        end else if (bus.req_valid === 1'b1 && !(c >= winStart && c <= winEnd)) begin
            if (accCount < 16) accCyc[accCount] = c;
            accCount++;
            if (int'(bus.req_col) < NCOLS && int'(bus.req_row) < NROWS) begin
                for (int y = 0; y < CELL_PX; y++)
                    for (int x = 0; x < CELL_PX; x++)
                        expQ.push_back('{cellAddr(int'(bus.req_col), int'(bus.req_row), x, y),
                                         cellData(int'(bus.req_index), x, y)});
                winStart = c + 1;
                winEnd   = c + 400;
                doneAt   = c + 401;
            end else begin
                errAt = c + 1;
            end
        end
        cyc = c + 1;
    end

    // Compare process, sampled mid-cycle.
    always @(negedge clock) begin
        int  c;
        bit  expW;
        wr_t e;
        c = cyc;
        if (c >= 1) begin
            expW = (c >= winStart && c <= winEnd);
            if (c == resetAt) begin
                lastA = 0;
                lastD = 0;
            end
            chk("wren", 32'(bus.wren), 32'(expW));
            chk("req_ready", 32'(bus.req_ready), 32'(!expW));
            chk("done", 32'(bus.done), 32'(c == doneAt));
            chk("err", 32'(bus.err), 32'(c == errAt));
            if (bus.done === 1'b1) doneCount++;
            if (bus.err === 1'b1) errCount++;
            if (bus.wren === 1'b1) begin
                chk("addr_in_frame", 32'(int'(bus.wr_addr) < SCREEN_W * SCREEN_H), 32'd1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    chk("wr_addr", 32'(bus.wr_addr), e.a);
                    chk("wr_data", 32'(bus.wr_data), e.d);
                end
                if (logCount < 4096) begin
                    addrLog[logCount] = int'(bus.wr_addr);
                    dataLog[logCount] = int'(bus.wr_data);
                end
                logCount++;
                lastA = int'(bus.wr_addr);
                lastD = int'(bus.wr_data);
            end else begin
                chk("wr_addr_hold", 32'(bus.wr_addr), lastA);
                chk("wr_data_hold", 32'(bus.wr_data), lastD);
            end
        end
    end

    task automatic sendReq(input int col, input int row, input int idx);
        @(posedge clock); #1;
        bus.req_valid = 1'b1;
        bus.req_col   = 4'(col);
        bus.req_row   = 5'(row);
        bus.req_index = 8'(idx);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark;
        int m0;
        int e0;
        int acc0;
        bit got;

        bus.req_valid = 1'b0;
        bus.req_col   = '0;
        bus.req_row   = '0;
        bus.req_index = '0;
        for (int i = 0; i < 16; i++) accCyc[i] = 0;

        waitCycles(3);
        reset = 1'b0;
        waitCycles(2);
        chk("reset_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_wren", 32'(bus.wren), 32'd0);
        chk("reset_addr", 32'(bus.wr_addr), 32'd0);
        chk("model_pin", cellAddr(9, 23, 19, 19), 306959);

        // Tile at board origin
        mark = logCount;
        m0   = doneCount;
        sendReq(0, 0, 5);
        waitCycles(402);
        chk("t1_count", logCount - mark, 400);
        chk("t1_first", addrLog[mark], 200);
        chk("t1_20th", addrLog[mark + 19], 219);
        chk("t1_21st", addrLog[mark + 20], 840);
        chk("t1_last", addrLog[mark + 399], 12379);
        chk("t1_corner_data", dataLog[mark], BORDER ? 1 : 5);
        chk("t1_inner_data", dataLog[mark + 25], 5);
        chk("t1_done", doneCount - m0, 1);

        // Bottom-right cell
        mark = logCount;
        sendReq(9, 23, 7);
        waitCycles(402);
        chk("t2_count", logCount - mark, 400);
        chk("t2_first", addrLog[mark], 294780);
        chk("t2_last", addrLog[mark + 399], 306959);

        // Out-of-range requests
        mark = logCount;
        e0   = errCount;
        sendReq(10, 0, 3);
        waitCycles(3);
        sendReq(0, 24, 3);
        waitCycles(3);
        chk("oor_writes", logCount - mark, 0);
        chk("oor_err_pulses", errCount - e0, 2);

        // req_valid held with changing fields across a whole tile
        mark = logCount;
        acc0 = accCount;
        @(posedge clock); #1;
        bus.req_valid = 1'b1;
        bus.req_col   = 4'd1;
        bus.req_row   = 5'd1;
        bus.req_index = 8'd3;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clock); #1;
            if (accCount >= acc0 + 2) break;
            bus.req_col   = 4'(2 + (i % 7));
            bus.req_row   = 5'(i % 20);
            bus.req_index = 8'(i + 10);
        end
        bus.req_valid = 1'b0;
        chk("t4_accepts", accCount - acc0, 2);
        chk("t4_gap", accCyc[acc0 + 1] - accCyc[acc0], 401);
        waitCycles(402);
        chk("t4_count", logCount - mark, 800);

        // Reset in the middle of a tile
        mark = logCount;
        sendReq(3, 5, 9);
        got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (logCount - mark >= 150) begin
                got = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        chk("t5_reached_150", 32'(got), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("t5_partial", logCount - mark, 151);
        chk("t5_ready_after_reset", 32'(bus.req_ready), 32'd1);
        waitCycles(2);
        mark = logCount;
        sendReq(4, 6, 2);
        waitCycles(402);
        chk("t5_count", logCount - mark, 400);
        chk("t5_first", addrLog[mark], 77080);
        chk("t5_last", addrLog[mark + 399], 89259);

        chk("queue_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_painter.md
# tile_painter

Write-side companion to the VGA display path: paints one 20×20-pixel board cell into the 640×480 colour-index frame memory that the display processor reads.
- Accepts a cell request (column, row, colour index) over a valid/ready handshake.
- Streams 400 single-pixel writes, one per clock, to the frame-memory write port.
- Sits between the game-logic processor and the index RAM's write port.

## Interface
Parameters:
- BOARD_X0, 200, screen x of board column 0 left edge
- BOARD_Y0, 0, screen y of board row 0 top edge
- COLS, 10, board columns
- ROWS, 24, board rows
- BORDER_INDEX, 8'd1, colour index for cell outline; used only when TILE_PAINTER_BORDER_EN is defined

Ports:
- clock  in  1  single clock for the block
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_col  in  4  board column
- req_row  in  5  board row
- req_index  in  8  colour index to paint
- wren  out  1  frame-memory write enable
- wr_addr  out  19  frame-memory address, y*640 + x
- wr_data  out  8  colour index written
- done  out  1  one-cycle pulse when a tile completes
- err  out  1  one-cycle pulse when an out-of-range request is dropped

## Operation
- FSM states: IDLE and PAINT.
- IDLE:
  - req_ready=1.
  - Accept occurs on req_valid && req_ready.
  - If req_col>=COLS or req_row>=ROWS: stay in IDLE, pulse err the next cycle, perform no writes.
  - Otherwise latch req_index and compute base = (BOARD_Y0 + row*20)*640 + BOARD_X0 + col*20, all arithmetic 19-bit unsigned. Then go to PAINT.
- PAINT:
  - req_ready=0.
  - Counters px and py (5-bit, each 0..19) plus a 19-bit row-base register. Row-base starts at base and gains 640 each time px wraps from 19 to 0.
  - wr_addr = rowbase + px, registered.
  - Scan is raster order: px increments each cycle. On px==19, px goes to 0 and py increments.
  - On the write with px==19 && py==19, return to IDLE.
- req_* inputs are ignored while in PAINT; nothing is queued.
- wr_data is the latched index, independent of later req_index changes.
- Reset, including mid-PAINT:
  - Next cycle: state=IDLE, wren=0, wr_addr=0, wr_data=0, done=0, err=0, req_ready=1, counters=0.
  - A partially painted tile stays partial.

## Timing
- Accept at cycle N → wren=1 for cycles N+1 through N+400 inclusive.
- First write is at base (px=py=0). Last write is at base+19*640+19.
- At N+401: done=1 for one cycle, req_ready=1, wren=0.
- A new request can be accepted at N+401, giving a throughput of 401 cycles per tile.
- Out-of-range accept at N → err=1 at N+1, req_ready stays 1.
- wren, wr_addr and wr_data are all registered. When wren=0, wr_addr and wr_data hold their last values.

## Configuration
- TILE_PAINTER_BORDER_EN defined:
  - Pixels with px==0, px==19, py==0 or py==19 are written with BORDER_INDEX (76 pixels per tile).
  - The 324 interior pixels are written with the latched index.
- Not defined: all 400 pixels are written with the latched index, and BORDER_INDEX is unused.
- Write count and timing are identical in both builds.

## Structure
- Shared package tetris_pkg holds:
  - SCREEN_W=640, SCREEN_H=480, CELL_PX=20
  - ADDR_W=19, INDEX_W=8
  - the painter state enum {IDLE, PAINT}
- One sub-module: tile_scan_counter.
  - Contains the px/py counters and the running row-base address.
  - Inputs: start with base; output: last-pixel flag.

## Test plan
- Reset, then req col=0 row=0 index=5 → exactly 400 writes:
  - first wr_addr=200, 20th=219, 21st=840, last=12379
  - all wr_data=5; done pulses 1 cycle after the last write.
- col=9 row=23 index=7 → first wr_addr=294780, last=306959; no address ≥307200.
- col=10 row=0 → no wren at all, err pulse at N+1, req_ready never drops.
- Hold req_valid high with changing fields during PAINT → no second accept until N+401; the next tile starts writing at N+402.
- Assert reset at write 150 → wren=0 the next cycle, req_ready=1, and a fresh request paints all 400 pixels correctly.
- With TILE_PAINTER_BORDER_EN and BORDER_INDEX=1, index=5 → 76 writes of 1 on the perimeter and 324 writes of 5 in the interior.
